eth_phy_rx_ber_mon_mlane: RTL

Multi-lane, parametrised BER monitor for the 10G/25G/40G PCS receive path. It checks the 2-bit sync header of every valid block on each lane and asserts a per-lane high-BER flag when too many invalid headers fall inside a 125 us window. It sits after the per-lane block-lock/gearbox stage and feeds the PCS receive state machines and status registers. It adds lock gating, header-valid qualification, a configurable threshold and per-lane saturating statistics counters.

---
 rtl/eth_phy_pkg.sv | 15 +
 rtl/eth_phy_rx_ber_mon_mlane_if.sv | 25 ++
 rtl/eth_phy_rx_ber_lane.sv | 92 +++++++++
 rtl/eth_phy_rx_ber_mon_mlane.sv | 66 ++++++
 4 files changed

// File: rtl/eth_phy_pkg.sv
// Shared PCS receive definitions: 64b/66b sync header codes and a header
// classification helper used by the BER monitor lanes.
package eth_phy_pkg;

    localparam int HDR_WIDTH = 2;

    localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b10;
    localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b01;

    // Only the two legal sync codes count as a good header; 00 and 11 are errors.
    function automatic logic hdr_is_valid(input logic [HDR_WIDTH-1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_rx_ber_mon_mlane_if.sv
// Bus between the gearbox/block-lock stage and the multi-lane BER monitor:
// per-lane headers, qualifiers and lock in, high-BER flags and statistics out.
interface eth_phy_rx_ber_mon_mlane_if #(
    parameter int LANE_COUNT    = 4,
    parameter int HDR_WIDTH     = eth_phy_pkg::HDR_WIDTH,
    parameter int BER_CNT_WIDTH = 6
);
    logic [LANE_COUNT*HDR_WIDTH-1:0]     serdes_rx_hdr;
    logic [LANE_COUNT-1:0]               serdes_rx_hdr_valid;
    logic [LANE_COUNT-1:0]               rx_block_lock;
    logic                                ber_count_clear;
    logic [LANE_COUNT-1:0]               rx_high_ber;
    logic                                rx_high_ber_any;
    logic [LANE_COUNT*BER_CNT_WIDTH-1:0] ber_count;

    modport master (
        output serdes_rx_hdr, serdes_rx_hdr_valid, rx_block_lock, ber_count_clear,
        input  rx_high_ber, rx_high_ber_any, ber_count
    );

    modport slave (
        input  serdes_rx_hdr, serdes_rx_hdr_valid, rx_block_lock, ber_count_clear,
        output rx_high_ber, rx_high_ber_any, ber_count
    );
endinterface

// File: rtl/eth_phy_rx_ber_lane.sv
// One lane of the BER monitor: windowed invalid-header count, high-BER flag and
// a saturating statistics counter (built only with ETH_PHY_BER_MON_STATS_EN).
module eth_phy_rx_ber_lane
    import eth_phy_pkg::*;
#(
    parameter int BER_THRESH    = 16,
    parameter int BER_CNT_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [HDR_WIDTH-1:0]     hdr,
    input  logic                     hdr_valid,
    input  logic                     block_lock,
    input  logic                     expire,
    input  logic                     cnt_clear,
    output logic                     high_ber,
    output logic [BER_CNT_WIDTH-1:0] ber_count
);
    localparam int CNT_W = $clog2(BER_THRESH + 1);
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(BER_THRESH);

    logic             hdr_bad;
    logic [CNT_W-1:0] win_cnt_reg, win_cnt_next, win_cnt_inc;
    logic             high_ber_reg, high_ber_next;
    logic             thresh_hit;

    assign hdr_bad = hdr_valid & block_lock & ~hdr_is_valid(hdr);

    always_comb begin
        win_cnt_inc   = (win_cnt_reg == THRESH_V) ? win_cnt_reg
                                                  : win_cnt_reg + CNT_W'(hdr_bad);
        thresh_hit    = (win_cnt_inc == THRESH_V);
        win_cnt_next  = win_cnt_reg;
        high_ber_next = high_ber_reg;
        if (!block_lock) begin
            win_cnt_next  = '0;
            high_ber_next = 1'b0;
        end else if (expire) begin
            // The header arriving in the expiry cycle still belongs to the closing window.
            high_ber_next = thresh_hit;
            win_cnt_next  = '0;
        end else begin
            win_cnt_next = win_cnt_inc;
            if (thresh_hit) begin
                high_ber_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_reg  <= '0;
            high_ber_reg <= 1'b0;
        end else begin
            win_cnt_reg  <= win_cnt_next;
            high_ber_reg <= high_ber_next;
        end
    end

    assign high_ber = high_ber_reg;

`ifdef ETH_PHY_BER_MON_STATS_EN
    localparam logic [BER_CNT_WIDTH-1:0] STAT_MAX = '1;

    logic [BER_CNT_WIDTH-1:0] stat_cnt_reg, stat_cnt_next;

    // A clear coinciding with an error restarts the count at one, not zero.
    always_comb begin
        stat_cnt_next = stat_cnt_reg;
        if (cnt_clear) begin
            stat_cnt_next = BER_CNT_WIDTH'(hdr_bad);
        end else if (hdr_bad && (stat_cnt_reg != STAT_MAX)) begin
            stat_cnt_next = stat_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt_reg <= '0;
        end else begin
            stat_cnt_reg <= stat_cnt_next;
        end
    end

    assign ber_count = stat_cnt_reg;
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear;
    assign ber_count        = '0;
`endif

endmodule

// File: rtl/eth_phy_rx_ber_mon_mlane.sv
// Multi-lane PCS receive BER monitor: shared 125 us window timer, per-lane
// monitors and a registered any-lane flag. Statistics need ETH_PHY_BER_MON_STATS_EN.
module eth_phy_rx_ber_mon_mlane #(
    parameter int LANE_COUNT    = 4,
    parameter int HDR_WIDTH     = eth_phy_pkg::HDR_WIDTH,
    parameter int COUNT_125US   = 19531,
    parameter int BER_THRESH    = 16,
    parameter int BER_CNT_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    eth_phy_rx_ber_mon_mlane_if.slave    bus
);
    localparam int TMR_W = (COUNT_125US < 1) ? 1 : $clog2(COUNT_125US + 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(COUNT_125US);

    generate
        if (HDR_WIDTH != 2) begin : g_bad_hdr_width
            $error("eth_phy_rx_ber_mon_mlane: HDR_WIDTH must be 2");
        end
    endgenerate

    logic [TMR_W-1:0]                    timer_reg, timer_next;
    logic                                expire;
    logic [LANE_COUNT-1:0]               high_ber_vec;
    logic [LANE_COUNT*BER_CNT_WIDTH-1:0] ber_count_vec;
    logic                                high_ber_any_reg;

    // Free-running window timer; lock and header-valid never pause it.
    assign expire     = (timer_reg == '0);
    assign timer_next = expire ? TMR_RELOAD : timer_reg - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_reg        <= TMR_RELOAD;
            high_ber_any_reg <= 1'b0;
        end else begin
            timer_reg        <= timer_next;
            high_ber_any_reg <= |high_ber_vec;
        end
    end

    generate
        for (genvar gi = 0; gi < LANE_COUNT; gi++) begin : g_lane
            eth_phy_rx_ber_lane #(
                .BER_THRESH   (BER_THRESH),
                .BER_CNT_WIDTH(BER_CNT_WIDTH)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .hdr       (bus.serdes_rx_hdr[gi*HDR_WIDTH +: HDR_WIDTH]),
                .hdr_valid (bus.serdes_rx_hdr_valid[gi]),
                .block_lock(bus.rx_block_lock[gi]),
                .expire    (expire),
                .cnt_clear (bus.ber_count_clear),
                .high_ber  (high_ber_vec[gi]),
                .ber_count (ber_count_vec[gi*BER_CNT_WIDTH +: BER_CNT_WIDTH])
            );
        end
    endgenerate

    assign bus.rx_high_ber     = high_ber_vec;
    assign bus.rx_high_ber_any = high_ber_any_reg;
    assign bus.ber_count       = ber_count_vec;

endmodule
